car_pos_wb_master: RTL and testbench

// - Wishbone initiator that drives the VGA peripheral's ROW_COL register (offset 0x0) from player buttons.
// - Keeps the yellow car's X position, saturated to the road lane limits, and writes {Y,X} on every change.
// - Reads the register back after each write to confirm it; sits between the button inputs and the VGA slave.

---
 rtl/car_wb_pkg.sv | 17 +
 rtl/car_pos_stepper.sv | 44 ++++
 rtl/car_pos_wb_master.sv | 89 ++++++++
 tb/tb_car_pos_wb_master.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/car_wb_pkg.sv
// car_wb_pkg: shared FSM states, register map and field layout for the car position master
package car_wb_pkg;
    typedef enum logic [1:0] {IDLE, WR, GAP, RD} state_t;
    localparam logic [31:0] ROW_COL_OFS = 32'h0;
    localparam logic [31:0] DATA_OFS = 32'h4;
    localparam int X_LSB = 0;
    localparam int X_MSB = 9;
    localparam int Y_LSB = 10;
    localparam int Y_MSB = 19;
    localparam int DEF_X_MIN = 269;
    localparam int DEF_X_MAX = 368;
    localparam int DEF_X_RESET = 305;
    localparam int DEF_Y_FIXED = 405;
    function automatic logic [31:0] row_col(input logic [9:0] y, input logic [9:0] x);
        return {12'b0, y, x};
    endfunction
endpackage

// File: rtl/car_pos_stepper.sv
// car_pos_stepper: synchronises the buttons and steps car X once per tick within the lane limits
module car_pos_stepper
    import car_wb_pkg::*;
#(
    parameter int X_MIN = DEF_X_MIN,
    parameter int X_MAX = DEF_X_MAX,
    parameter int X_RESET = DEF_X_RESET,
    parameter int STEP = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       tick_i,
    output logic [9:0] x,
    output logic       changed
);
    localparam logic [9:0] LO = 10'(X_MIN);
    localparam logic [9:0] HI = 10'(X_MAX);
    localparam logic [9:0] ST = 10'(STEP);
    localparam logic [9:0] LO_ST = 10'(X_MIN + STEP);
    localparam logic [9:0] HI_ST = 10'(X_MAX - STEP);
    logic [1:0] sync_l, sync_r;
    logic [9:0] x_n;
    // thresholds are pre-offset by STEP so the step never wraps before saturating
    always_comb begin
        x_n = !tick_i ? x
            : sync_l[1] && !sync_r[1] ? (x < LO_ST ? LO : x - ST)
            : sync_r[1] && !sync_l[1] ? (x > HI_ST ? HI : x + ST)
            : x;
        changed = x_n != x;
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_l <= '0;
            sync_r <= '0;
            x <= 10'(X_RESET);
        end else begin
            sync_l <= {sync_l[0], btn_left_i};
            sync_r <= {sync_r[0], btn_right_i};
            x <= x_n;
        end
    end
endmodule

// File: rtl/car_pos_wb_master.sv
// car_pos_wb_master: writes the car {Y,X} to the VGA ROW_COL register and reads it back to confirm
module car_pos_wb_master
    import car_wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [AW-1:0] VGA_BASE = '0,
    parameter int X_MIN = DEF_X_MIN,
    parameter int X_MAX = DEF_X_MAX,
    parameter int X_RESET = DEF_X_RESET,
    parameter int Y_FIXED = DEF_Y_FIXED,
    parameter int STEP = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          btn_left_i,
    input  logic          btn_right_i,
    input  logic          tick_i,
    output logic          m_wb_cyc_o,
    output logic          m_wb_stb_o,
    output logic          m_wb_we_o,
    output logic [AW-1:0] m_wb_adr_o,
    output logic [DW-1:0] m_wb_dat_o,
    output logic [3:0]    m_wb_sel_o,
    input  logic [DW-1:0] m_wb_dat_i,
    input  logic          m_wb_ack_i,
    input  logic          m_wb_err_i,
    output logic [9:0]    car_x_o,
    output logic          busy_o,
    output logic          mismatch_o,
    output logic          timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_n;
    logic changed, pending, hold, go, ack, err, abort, active, unused_hi;
    logic [CW-1:0] cnt;
    car_pos_stepper #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .X_RESET(X_RESET), .STEP(STEP)
    ) u_stepper (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .btn_left_i(btn_left_i),
        .btn_right_i(btn_right_i), .tick_i(tick_i), .x(car_x_o), .changed(changed)
    );
    assign unused_hi = ^m_wb_dat_i[DW-1:20];
    assign busy_o = state != IDLE;
    // terminations only count while a cycle is actually on the bus
    always_comb begin
        ack = m_wb_cyc_o & m_wb_ack_i & ~m_wb_err_i;
        err = m_wb_cyc_o & m_wb_err_i;
        abort = err | (m_wb_cyc_o & ~m_wb_ack_i & cnt == CW'(TIMEOUT - 1));
        go = state == IDLE && pending && (!hold || tick_i);
        state_n = state == IDLE ? (go ? WR : IDLE)
                : state == GAP ? RD
                : abort ? IDLE
                : !ack ? state
                : state == WR ? GAP : IDLE;
        active = (state_n == WR || state_n == RD) && state != IDLE;
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            m_wb_we_o <= 1'b0;
            m_wb_adr_o <= '0;
            m_wb_dat_o <= '0;
            m_wb_sel_o <= '0;
            pending <= 1'b1;
            hold <= 1'b0;
            cnt <= '0;
            mismatch_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state <= state_n;
            m_wb_cyc_o <= active;
            m_wb_stb_o <= active;
            m_wb_we_o <= active && state_n == WR;
            m_wb_adr_o <= active ? VGA_BASE + AW'(ROW_COL_OFS) : '0;
            m_wb_sel_o <= active ? 4'hF : 4'h0;
            if (go) m_wb_dat_o <= DW'(row_col(10'(Y_FIXED), car_x_o));
            pending <= changed | abort | (pending & ~go);
            // an aborted write waits for the next frame tick before retrying
            hold <= abort | (hold & ~tick_i);
            cnt <= m_wb_cyc_o && !ack && !err ? cnt + 1'b1 : '0;
            mismatch_o <= mismatch_o | (state == RD && ack && m_wb_dat_i[19:0] != m_wb_dat_o[19:0]);
            timeout_o <= timeout_o | abort;
        end
    end
endmodule

// File: tb/tb_car_pos_wb_master.sv
// tb_car_pos_wb_master: directed button/tick stimulus with a queued scoreboard of expected bus transactions
module tb_car_pos_wb_master;
    logic clk = 0, rst = 1, btn_l = 0, btn_r = 0, tick = 0;
    logic cyc, stb, we, ack = 0, err = 0, busy, mism, tmo;
    logic [31:0] adr, dat_o, dat_i, reg_q;
    logic [3:0] sel;
    logic [9:0] car_x;
    logic ack_en = 1, bad = 0, stb_d = 0;
    typedef struct {logic we; logic [31:0] dat;} txn_t;
    txn_t exp_q[$];
    int checks = 0, passes = 0, extra = 0, txn_cnt = 0, run = 0, last_run = 0, base = 0, n = 0;

    always #5 clk = ~clk;

    car_pos_wb_master dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .btn_left_i(btn_l), .btn_right_i(btn_r), .tick_i(tick),
        .m_wb_cyc_o(cyc), .m_wb_stb_o(stb), .m_wb_we_o(we), .m_wb_adr_o(adr), .m_wb_dat_o(dat_o),
        .m_wb_sel_o(sel), .m_wb_dat_i(dat_i), .m_wb_ack_i(ack), .m_wb_err_i(err),
        .car_x_o(car_x), .busy_o(busy), .mismatch_o(mism), .timeout_o(tmo)
    );

    // one-wait-state slave holding the ROW_COL register
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 0;
            reg_q <= 0;
        end else begin
            ack <= ack_en & cyc & stb & ~ack;
            if (ack && cyc && stb && we) reg_q <= dat_o;
        end
    end
    assign dat_i = bad ? 32'h00065530 : reg_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_txn(input logic [9:0] x);
        exp_q.push_back('{1'b1, 32'h00065400 | {22'b0, x}});
        exp_q.push_back('{1'b0, 32'h00065400 | {22'b0, x}});
    endtask

    task automatic pulse();
        @(negedge clk) tick = 1;
        @(negedge clk) tick = 0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        chk(name, busy, 0);
    endtask

    always @(negedge clk) begin
        txn_t t;
        if (stb && !stb_d) begin
            txn_cnt++;
            if (exp_q.size() == 0) extra++;
            else begin
                t = exp_q.pop_front();
                chk("txn_we", we, t.we);
                chk("txn_adr", adr, 0);
                chk("txn_sel", sel, 4'hF);
                if (t.we) chk("txn_wdat", dat_o, t.dat);
            end
        end
        if (stb) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        stb_d = stb;
    end

    initial begin
        push_txn(10'd305);
        repeat (3) @(negedge clk);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x", car_x, 305);
        chk("rst_mism", mism, 0);
        chk("rst_tmo", tmo, 0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1 chk("lat_edge1_stb", stb, 0);
        @(posedge clk); #1 chk("lat_edge2_stb", stb, 1);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("txn_cycles", n, 5);
        chk("first_mism", mism, 0);

        base = txn_cnt;
        btn_l = 1; btn_r = 1;
        repeat (3) @(negedge clk);
        repeat (10) pulse();
        chk("both_x", car_x, 305);
        chk("both_no_txn", txn_cnt, base);
        btn_l = 0; btn_r = 0;
        repeat (3) @(negedge clk);

        btn_r = 1;
        repeat (3) @(negedge clk);
        for (int k = 1; k <= 16; k++) push_txn(k == 16 ? 10'd368 : 10'(305 + 4 * k));
        base = txn_cnt;
        repeat (20) pulse();
        chk("right_x", car_x, 368);
        chk("right_txns", txn_cnt - base, 32);
        chk("right_q", exp_q.size(), 0);
        btn_r = 0;
        repeat (3) @(negedge clk);

        ack_en = 0;
        btn_l = 1;
        repeat (3) @(negedge clk);
        exp_q.push_back('{1'b1, 32'h0006556C});
        @(negedge clk) tick = 1;
        @(negedge clk) tick = 0;
        btn_l = 0;
        for (int i = 0; i < 40 && !tmo; i++) @(negedge clk);
        chk("to_flag", tmo, 1);
        chk("to_cyc", cyc, 0);
        chk("to_stb", stb, 0);
        repeat (2) @(negedge clk);
        chk("to_stb_len", last_run, 15);
        chk("to_x", car_x, 364);
        ack_en = 1;
        base = txn_cnt;
        repeat (20) @(negedge clk);
        chk("to_no_early_retry", txn_cnt, base);
        push_txn(10'd364);
        pulse();
        wait_idle("retry_idle");
        chk("retry_tmo_sticky", tmo, 1);
        chk("retry_mism", mism, 0);

        bad = 1;
        btn_r = 1;
        repeat (3) @(negedge clk);
        push_txn(10'd368);
        pulse();
        btn_r = 0;
        wait_idle("bad_idle");
        chk("mism_set", mism, 1);
        bad = 0;
        btn_l = 1;
        repeat (3) @(negedge clk);
        push_txn(10'd364);
        pulse();
        btn_l = 0;
        wait_idle("good_idle");
        chk("mism_sticky", mism, 1);

        btn_r = 1;
        repeat (3) @(negedge clk);
        exp_q.push_back('{1'b1, 32'h00065570});
        @(negedge clk) tick = 1;
        @(negedge clk) tick = 0;
        btn_r = 0;
        for (int i = 0; i < 20 && !stb; i++) @(negedge clk);
        chk("mid_stb_seen", stb, 1);
        @(posedge clk); #1 rst = 1;
        #1 chk("mid_rst_cyc", cyc, 0);
        chk("mid_rst_stb", stb, 0);
        chk("mid_rst_busy", busy, 0);
        push_txn(10'd305);
        repeat (2) @(negedge clk);
        rst = 0;
        wait_idle("mid_rst_idle");
        chk("mid_rst_x", car_x, 305);
        chk("mid_rst_mism", mism, 0);
        chk("mid_rst_tmo", tmo, 0);

        repeat (5) @(negedge clk);
        chk("q_empty", exp_q.size(), 0);
        chk("no_extra_txn", extra, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
